// File: rtl/bldc_commutator.sv
// rtl/bldc_commutator.sv - six-step BLDC commutation controller with dead time, PWM and latched fault
//
// Sequences the six gate-drive outputs from three Hall sensors and a duty word.
// Hall inputs are synchronised, decoded to a commutation pattern, and every
// change of the applied pattern is preceded by an all-off dead-time window.
// The applied pattern is chopped by a free-running PWM whose duty only changes
// at a period boundary.
//
// Optional feature macro: BLDC_STALL_DETECT_EN (stall timeout -> FAULT).
//
// Ports:
//   iCLK       system clock
//   iRESETn    asynchronous active-low reset
//   iEN        run enable; low forces IDLE and clears a fault
//   iDIR       0 = forward, 1 = reverse
//   iDUTY      requested PWM duty, unsigned
//   iHALL      raw Hall inputs {U,V,W}, asynchronous
//   oPHASES    gate-drive pattern {UH,UL,VH,VL,WH,WL}
//   oFAULT     latched fault flag
//   oSTEP_CNT  signed commutation step count, wraps
module bldc_commutator #(
   parameter int DEAD_CYCLES  = 24,
   parameter int PWM_BITS     = 11,
   parameter int STALL_CYCLES = 2400000
) (
   input  logic                iCLK,
   input  logic                iRESETn,
   input  logic                iEN,
   input  logic                iDIR,
   input  logic [PWM_BITS-1:0] iDUTY,
   input  logic [2:0]          iHALL,
   output logic [5:0]          oPHASES,
   output logic                oFAULT,
   output logic [15:0]         oSTEP_CNT
);

   if (DEAD_CYCLES < 1 || DEAD_CYCLES > 255 || STALL_CYCLES < 1) begin : gBadParam
      $error("bldc_commutator: DEAD_CYCLES must be 1..255 and STALL_CYCLES >= 1");
   end

   localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;
   localparam logic [7:0]          DEAD_LOAD = 8'(DEAD_CYCLES);

   typedef enum logic [1:0] {IDLE, DEAD, RUN, FAULT} tState;

   tState               state, stateNext;
   logic [7:0]          deadCnt, deadCntNext;
   logic [5:0]          appliedPattern, appliedNext;
   logic [5:0]          decPattern;
   logic [2:0]          hallMeta, hallSync, hallHist;
   logic [PWM_BITS-1:0] pwmCnt, dutyLatched;
   logic                syncValid, histValid, validChange, invalidHall, forwardStep;
   logic                pwmGate, stallHit;

   // Forward commutation table, indexed by the (direction-adjusted) Hall code.
   function automatic logic [5:0] decodeHall(input logic [2:0] h);
      case (h)
         3'b101:  decodeHall = 6'b100100;
         3'b100:  decodeHall = 6'b100001;
         3'b110:  decodeHall = 6'b001001;
         3'b010:  decodeHall = 6'b011000;
         3'b011:  decodeHall = 6'b010010;
         3'b001:  decodeHall = 6'b000110;
         default: decodeHall = 6'b000000;
      endcase
   endfunction

   // Next Hall code in forward rotation order.
   function automatic logic [2:0] fwdSucc(input logic [2:0] h);
      case (h)
         3'b101:  fwdSucc = 3'b100;
         3'b100:  fwdSucc = 3'b110;
         3'b110:  fwdSucc = 3'b010;
         3'b010:  fwdSucc = 3'b011;
         3'b011:  fwdSucc = 3'b001;
         3'b001:  fwdSucc = 3'b101;
         default: fwdSucc = 3'b000;
      endcase
   endfunction

   assign syncValid   = (hallSync != 3'b000) && (hallSync != 3'b111);
   assign histValid   = (hallHist != 3'b000) && (hallHist != 3'b111);
   assign validChange = syncValid && histValid && (hallSync != hallHist);
   // Two consecutive invalid samples; a single-cycle glitch is tolerated.
   assign invalidHall = !syncValid && !histValid;
   assign forwardStep = (hallSync == fwdSucc(hallHist));
   assign pwmGate     = pwmCnt > (PWM_MAX - dutyLatched);

   // Hall synchroniser, history, decoded pattern and step counter.
   // The decoded pattern holds its last valid value while the Hall code is
   // invalid, so an invalid code leads to FAULT rather than a dead-time cycle.
   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         hallMeta   <= 3'b000;
         hallSync   <= 3'b000;
         hallHist   <= 3'b000;
         decPattern <= 6'b000000;
         oSTEP_CNT  <= 16'd0;
      end else begin
         hallMeta <= iHALL;
         hallSync <= hallMeta;
         hallHist <= hallSync;
         if (syncValid) begin
            decPattern <= decodeHall(iDIR ? ~hallSync : hallSync);
         end
         if (validChange) begin
            oSTEP_CNT <= forwardStep ? oSTEP_CNT + 16'd1 : oSTEP_CNT - 16'd1;
         end
      end
   end

   // Free-running PWM; duty is only sampled on the last count of a period.
   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         pwmCnt      <= '0;
         dutyLatched <= '0;
      end else begin
         pwmCnt <= pwmCnt + 1'b1;
         if (pwmCnt == PWM_MAX) begin
            dutyLatched <= iDUTY;
         end
      end
   end

`ifdef BLDC_STALL_DETECT_EN
   localparam logic [21:0] STALL_LIMIT = 22'(STALL_CYCLES - 1);
   logic [21:0] stallCnt;

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         stallCnt <= '0;
      end else if (validChange || state != RUN) begin
         stallCnt <= '0;
      end else if (dutyLatched != '0 && stallCnt != STALL_LIMIT) begin
         stallCnt <= stallCnt + 22'd1;
      end
   end

   assign stallHit = (state == RUN) && (dutyLatched != '0) && !validChange &&
                     (stallCnt == STALL_LIMIT);
`else
   assign stallHit = 1'b0;
`endif

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         state          <= IDLE;
         deadCnt        <= 8'd0;
         appliedPattern <= 6'b000000;
      end else begin
         state          <= stateNext;
         deadCnt        <= deadCntNext;
         appliedPattern <= appliedNext;
      end
   end

   // deadCnt holds the number of all-off cycles still to go; the last one
   // hands over to RUN.
   always_comb begin
      stateNext   = state;
      deadCntNext = deadCnt;
      appliedNext = appliedPattern;
      case (state)
         IDLE: begin
            if (iEN) begin
               stateNext   = DEAD;
               deadCntNext = DEAD_LOAD;
            end
         end
         DEAD: begin
            if (validChange) begin
               deadCntNext = DEAD_LOAD;
            end else if (deadCnt <= 8'd1) begin
               stateNext   = RUN;
               deadCntNext = 8'd0;
               appliedNext = decPattern;
            end else begin
               deadCntNext = deadCnt - 8'd1;
            end
         end
         RUN: begin
            if (invalidHall || stallHit) begin
               stateNext = FAULT;
            end else if (decPattern != appliedPattern) begin
               stateNext   = DEAD;
               deadCntNext = DEAD_LOAD;
            end
         end
         FAULT: begin
            stateNext = FAULT;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
      if (!iEN) begin
         stateNext   = IDLE;
         deadCntNext = 8'd0;
      end
   end

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         oPHASES <= 6'b000000;
         oFAULT  <= 1'b0;
      end else begin
         oPHASES <= (state == RUN) ? (appliedPattern & {6{pwmGate}}) : 6'b000000;
         oFAULT  <= (state == FAULT);
      end
   end

endmodule
